// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// Consumers: ex_muldiv (build option MULDIV_DIV_EN selects the divider).
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic op_a_signed(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: op_a_signed = 1'b1;
      default:                            op_a_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_DIV, F3_REM: op_b_signed = 1'b1;
      default:                 op_b_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Combinational two's-complement conditional negate, used both for operand
// magnitudes and for sign correction of the final result.
module muldiv_abs #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] val_i,
  input  logic            neg_i,
  output logic [XLEN-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + {{(XLEN-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage (radix-2, one step per cycle).
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops complete as illegal.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     bmag_q, bmag_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  logic                accept_s;
  logic                sgn_a_s, sgn_b_s;
  logic [XLEN-1:0]     amag_s, bmag_s;
  logic [XLEN:0]       madd_s;
  logic [2*XLEN-1:0]   mul_step_s;
  logic [2*XLEN-1:0]   neg_in_s, res_full_s;
  logic [XLEN-1:0]     fin_res_s;

  assign accept_s = (state_q == ST_IDLE) & start_i & ~flush_i;
  assign sgn_a_s  = op_a_signed(funct3_i) & a_i[XLEN-1];
  assign sgn_b_s  = op_b_signed(funct3_i) & b_i[XLEN-1];

  muldiv_abs #(.XLEN(XLEN)) u_abs_a (.val_i(a_i), .neg_i(sgn_a_s), .res_o(amag_s));
  muldiv_abs #(.XLEN(XLEN)) u_abs_b (.val_i(b_i), .neg_i(sgn_b_s), .res_o(bmag_s));
  muldiv_abs #(.XLEN(2*XLEN)) u_abs_res (.val_i(neg_in_s), .neg_i(neg_q), .res_o(res_full_s));

  // Shift-add: the multiplier sits in the low half and drains out as the product fills in.
  assign madd_s     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : {(XLEN+1){1'b0}});
  assign mul_step_s = {madd_s, acc_q[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]       rsh_s;
  logic [XLEN-1:0]     rdiff_s;
  logic                rge_s;
  logic [2*XLEN-1:0]   div_step_s;

  // Restoring divide: remainder in the high half, dividend/quotient in the low half.
  assign rsh_s      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rge_s      = (rsh_s >= {1'b0, bmag_q});
  assign rdiff_s    = rsh_s[XLEN-1:0] - bmag_q;
  assign div_step_s = rge_s ? {rdiff_s, acc_q[XLEN-2:0], 1'b1}
                            : {rsh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  assign illegal_o  = 1'b0;
`else
  logic                ill_pend_q, ill_pend_d;
  logic                illegal_q, illegal_d;
  assign illegal_o  = illegal_q;
`endif

  // Select the value to sign-correct and the half of it that becomes the result.
  always_comb begin
    neg_in_s  = acc_q;
    fin_res_s = res_full_s[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1]) begin
        neg_in_s = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
      end else begin
        neg_in_s = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
      end
      fin_res_s = res_full_s[XLEN-1:0];
    end else if (op_q == F3_MUL) begin
      fin_res_s = res_full_s[XLEN-1:0];
    end else begin
      fin_res_s = res_full_s[2*XLEN-1:XLEN];
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bmag_d   = bmag_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifndef MULDIV_DIV_EN
    ill_pend_d = ill_pend_q;
    illegal_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = funct3_i;
          bmag_d  = bmag_s;
          cnt_d   = CNT_W'(XLEN);
          acc_d   = {{XLEN{1'b0}}, amag_s};
          neg_d   = (funct3_i[2] && funct3_i[1]) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
          state_d = ST_CALC;
`ifdef MULDIV_DIV_EN
          if (funct3_i[2] && (b_i == {XLEN{1'b0}})) begin
            acc_d   = {a_i, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            state_d = ST_FIN;
          end else if (funct3_i[2] && !funct3_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (b_i == {XLEN{1'b1}})) begin
            acc_d   = {{XLEN{1'b0}}, a_i};
            neg_d   = 1'b0;
            state_d = ST_FIN;
          end else begin
            state_d = ST_CALC;
          end
`else
          ill_pend_d = funct3_i[2];
          if (funct3_i[2]) begin
            acc_d   = {(2*XLEN){1'b0}};
            neg_d   = 1'b0;
            state_d = ST_FIN;
          end else begin
            state_d = ST_CALC;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
`ifdef MULDIV_DIV_EN
          acc_d = op_q[2] ? div_step_s : mul_step_s;
`else
          acc_d = mul_step_s;
`endif
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          result_d = fin_res_s;
          done_d   = 1'b1;
`ifndef MULDIV_DIV_EN
          illegal_d = ill_pend_q;
`endif
        end else begin
          done_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything so no stale op survives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      acc_q      <= {(2*XLEN){1'b0}};
      bmag_q     <= {XLEN{1'b0}};
      op_q       <= 3'b000;
      neg_q      <= 1'b0;
      result_q   <= {XLEN{1'b0}};
      done_q     <= 1'b0;
`ifndef MULDIV_DIV_EN
      ill_pend_q <= 1'b0;
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      bmag_q     <= bmag_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      result_q   <= result_d;
      done_q     <= done_d;
`ifndef MULDIV_DIV_EN
      ill_pend_q <= ill_pend_d;
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign busy_o   = (state_q == ST_CALC);
  assign stall_o  = ~rst_i & (accept_s | busy_o);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against a plain-arithmetic RV32M model.
// Follows the MULDIV_DIV_EN build option of the design.
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .funct3_i(funct3_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: result, illegal flag and cycles from accept edge to visible done_o.
  task automatic ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ill = 1'b0;
    lat = 33;
    res = 32'd0;
    case (f3)
      3'b000: begin up = ua * ub; res = up[31:0]; end
      3'b001: begin sp = sa * sb; res = sp[63:32]; end
      3'b010: begin sp = sa * longint'(ub); res = sp[63:32]; end
      3'b011: begin up = ua * ub; res = up[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 1;
          res = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 1;
          res = f3[1] ? 32'd0 : a;
        end else if (f3[0]) begin
          up  = f3[1] ? (ua % ub) : (ua / ub);
          res = up[31:0];
        end else begin
          sp  = f3[1] ? (sa % sb) : (sa / sb);
          res = sp[31:0];
        end
`else
        lat = 1;
        ill = 1'b1;
        res = 32'd0;
`endif
      end
    endcase
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit junk);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          n;
    int          stalls;
    logic        busy0;
    bit          seen;
    string       id;
    ref_op(f3, a, b, er, ei, el);
    id = $sformatf("f3=%0d a=%h b=%h", f3, a, b);
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b; flush_i = 1'b0;
    #1;
    stalls = stall_o ? 1 : 0;
    busy0 = 1'b0; seen = 1'b0; n = 0;
    while (!seen && n <= el + 4) begin
      @(negedge clk_i);
      if (n == 0) busy0 = busy_o;
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (stall_o) stalls++;
        if (junk && n < el) begin
          start_i  = 1'($urandom);
          funct3_i = 3'($urandom);
          a_i      = $urandom;
          b_i      = $urandom;
        end else begin
          start_i = 1'b0;
        end
        n++;
      end
    end
    start_i = 1'b0;
    check_eq({"latency ", id}, 64'(n), 64'(el));
    check_eq({"result ", id}, {32'd0, result_o}, {32'd0, er});
    check_eq({"illegal ", id}, {63'd0, illegal_o}, {63'd0, ei});
    check_eq({"stall_cycles ", id}, 64'(stalls), (el == 1) ? 64'd1 : 64'd33);
    check_eq({"busy_first ", id}, {63'd0, busy0}, {63'd0, (el > 1)});
    @(negedge clk_i);
    check_eq({"done_pulse ", id}, {63'd0, done_o}, 64'd0);
    check_eq({"result_hold ", id}, {32'd0, result_o}, {32'd0, er});
  endtask

  task automatic flush_test(input int at);
    int dones;
    @(negedge clk_i);
`ifdef MULDIV_DIV_EN
    funct3_i = 3'b101;
`else
    funct3_i = 3'b011;
`endif
    start_i = 1'b1; a_i = $urandom; b_i = $urandom | 32'd1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int m = 1; m <= at; m++) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_eq($sformatf("flush_busy at=%0d", at), {63'd0, busy_o}, 64'd0);
    check_eq($sformatf("flush_stall at=%0d", at), {63'd0, stall_o}, 64'd0);
    dones = done_o ? 1 : 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check_eq($sformatf("flush_no_done at=%0d", at), 64'(dones), 64'd0);
  endtask

  initial begin
    logic [31:0] vals [5];
    int dones;
    rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0; funct3_i = 3'b000; a_i = 32'd5; b_i = 32'd6;
    #1;
    check_eq("rst_done", {63'd0, done_o}, 64'd0);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst_result", {32'd0, result_o}, 64'd0);
    check_eq("rst_illegal", {63'd0, illegal_o}, 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b101, 32'd1234, 32'd0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b111, 32'd9, 32'd4, 1'b0);
    run_op(3'b000, 32'd3, 32'd4, 1'b0);

    // start together with flush in IDLE must not be accepted
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; a_i = 32'd2; b_i = 32'd2;
    #1;
    check_eq("flush_start_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    check_eq("flush_start_busy", {63'd0, busy_o}, 64'd0);
    check_eq("flush_start_done", {63'd0, done_o}, 64'd0);

    flush_test(9);
    run_op(3'b000, 32'd11, 32'd13, 1'b0);
    flush_test(32);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // asynchronous reset on the fifth CALC cycle
    run_op(3'b000, 32'd3, 32'd5, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b011; a_i = 32'hDEAD_BEEF; b_i = 32'h1234_5678;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2;
    rst_i = 1'b1; start_i = 1'b1;
    #1;
    check_eq("midrst_done", {63'd0, done_o}, 64'd0);
    check_eq("midrst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("midrst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("midrst_result", {32'd0, result_o}, 64'd0);
    check_eq("midrst_illegal", {63'd0, illegal_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check_eq("midrst_no_done", 64'(dones), 64'd0);

    vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
    vals[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? vals[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? vals[$urandom_range(0, 4)] : $urandom;
      run_op(3'($urandom), ra, rb, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
